cpu_run_ctrl: RTL

Run-control block that sits between the top-level SingleCycleCPU harness and the CPU core, replacing the fixed "hold reset, run N ns, stop" test fixture with synthesizable control. It sequences the core's reset, gates the core's clock enable, and supports free-run, single-step, PC breakpoint and cycle-budget stopping. It exposes a cycle count and stop cause, so benches and on-board debug can use the same block.

---
 rtl/cpu_run_pkg.sv | 35 +++
 rtl/run_edge_det.sv | 28 ++
 rtl/cpu_run_ctrl.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/cpu_run_pkg.sv
// Purpose: shared state codes, stop-cause codes and stop-priority helper for cpu run control.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package cpu_run_pkg;

   typedef enum logic [2:0] {
      ST_HOLD = 3'd0,
      ST_IDLE = 3'd1,
      ST_RUN  = 3'd2,
      ST_STEP = 3'd3,
      ST_DONE = 3'd4
   } run_state_t;

   typedef enum logic [1:0] {
      CAUSE_NONE  = 2'd0,
      CAUSE_HALT  = 2'd1,
      CAUSE_BP    = 2'd2,
      CAUSE_LIMIT = 2'd3
   } done_cause_t;

   // Halt outranks breakpoint, breakpoint outranks the cycle budget.
   function automatic done_cause_t stop_cause(input logic halt,
                                              input logic bp_hit,
                                              input logic lim_hit);
      if (halt)
         return CAUSE_HALT;
      else if (bp_hit)
         return CAUSE_BP;
      else if (lim_hit)
         return CAUSE_LIMIT;
      else
         return CAUSE_NONE;
   endfunction

endpackage

// File: rtl/run_edge_det.sv
// Purpose: registered rising-edge detector for a level input (used for the step request).
// Latency: rise is combinational from sig and the previous-cycle sample.
// Backpressure: none; samples every cycle.
// Ports: clk, rst_n (async active-low), sig (level in), rise (sig & ~previous sig).
module run_edge_det (
   input  logic clk,
   input  logic rst_n,
   input  logic sig,
   output logic rise
);

   logic sig_q;
   logic sig_d;

   always_comb begin
      sig_d = sig;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         sig_q <= 1'b0;
      else
         sig_q <= sig_d;
   end

   assign rise = sig & ~sig_q;

endmodule

// File: rtl/cpu_run_ctrl.sv
// Purpose: run control for a CPU core: reset sequencing, clock-enable gating, run/step/breakpoint/budget stop.
// Latency: cpu_en combinational from state and inputs; state/count/cause update on the next CLK edge.
// Backpressure: none; start/step/clear are levels or pulses sampled every cycle.
// Ports: CLK, Reset (async active-low); start, clear, step_mode, step, max_cycles, bp_en, bp_addr,
//        cpu_pc, cpu_halt in; cpu_rst_n, cpu_en, state, cycle_count, done, done_cause out.
module cpu_run_ctrl
   import cpu_run_pkg::*;
#(
   parameter int PC_W       = 32,
   parameter int CNT_W      = 16,
   parameter int RESET_HOLD = 4
) (
   input  logic             CLK,
   input  logic             Reset,
   input  logic             start,
   input  logic             clear,
   input  logic             step_mode,
   input  logic             step,
   input  logic [CNT_W-1:0] max_cycles,
   input  logic             bp_en,
   input  logic [PC_W-1:0]  bp_addr,
   input  logic [PC_W-1:0]  cpu_pc,
   input  logic             cpu_halt,
   output logic             cpu_rst_n,
   output logic             cpu_en,
   output logic [2:0]       state,
   output logic [CNT_W-1:0] cycle_count,
   output logic             done,
   output logic [1:0]       done_cause
);

   localparam int HOLD_W = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD - 1);

   run_state_t       state_q, state_d;
   logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
   logic [CNT_W-1:0] cycle_count_q, cycle_count_d;
   done_cause_t      cause_q, cause_d;
   logic             skip_bp_q, skip_bp_d;

   logic             step_rise;
   done_cause_t      hit_cause;
   logic             grant;
   logic             stop_hit;
   logic             exec;

   run_edge_det u_step_edge (
      .clk   (CLK),
      .rst_n (Reset),
      .sig   (step),
      .rise  (step_rise)
   );

   // Stop check: only meaningful on a cycle that would otherwise execute.
   // skip_bp lets the breakpointed instruction run once after a resume.
   always_comb begin
      hit_cause = stop_cause(cpu_halt,
                             bp_en && (cpu_pc == bp_addr) && !skip_bp_q,
                             (max_cycles != '0) && (cycle_count_q == max_cycles));
      grant     = (state_q == ST_RUN) || ((state_q == ST_STEP) && step_rise);
      stop_hit  = grant && (hit_cause != CAUSE_NONE);
      exec      = grant && !stop_hit && !clear;
   end

   // Next-state and datapath updates.
   always_comb begin
      state_d       = state_q;
      hold_cnt_d    = '0;
      cycle_count_d = cycle_count_q;
      cause_d       = cause_q;
      skip_bp_d     = skip_bp_q;

      if (clear) begin
         // Clear wins over start and any stop condition.
         state_d       = ST_HOLD;
         cycle_count_d = '0;
         cause_d       = CAUSE_NONE;
         skip_bp_d     = 1'b0;
      end else begin
         case (state_q)
            ST_HOLD: begin
               cycle_count_d = '0;
               if (hold_cnt_q == HOLD_LAST)
                  state_d = ST_IDLE;
               else
                  hold_cnt_d = hold_cnt_q + HOLD_W'(1);
            end
            ST_IDLE: begin
               // A step edge coinciding with start is absorbed by the edge register.
               if (start)
                  state_d = step_mode ? ST_STEP : ST_RUN;
            end
            ST_RUN, ST_STEP: begin
               if (stop_hit) begin
                  state_d = ST_DONE;
                  cause_d = hit_cause;
               end
            end
            ST_DONE: begin
               // A halted core can only be left by clear or Reset.
               if (start && (cause_q != CAUSE_HALT)) begin
                  state_d = step_mode ? ST_STEP : ST_RUN;
                  cause_d = CAUSE_NONE;
                  if (cause_q == CAUSE_BP)
                     skip_bp_d = 1'b1;
               end
            end
            default: state_d = ST_HOLD;
         endcase

         if (exec) begin
            skip_bp_d = 1'b0;
            if (cycle_count_q != '1)
               cycle_count_d = cycle_count_q + CNT_W'(1);
         end
      end
   end

   // Outputs.
   always_comb begin
      cpu_rst_n = (state_q != ST_HOLD);
      cpu_en    = exec;
      done      = (state_q == ST_DONE);
   end

   assign state       = state_q;
   assign cycle_count = cycle_count_q;
   assign done_cause  = cause_q;

   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         state_q       <= ST_HOLD;
         hold_cnt_q    <= '0;
         cycle_count_q <= '0;
         cause_q       <= CAUSE_NONE;
         skip_bp_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         hold_cnt_q    <= hold_cnt_d;
         cycle_count_q <= cycle_count_d;
         cause_q       <= cause_d;
         skip_bp_q     <= skip_bp_d;
      end
   end

endmodule
